align_shift_unit: RTL
=====================

# align_shift_unit

Multi-cycle operand alignment stage for the FP32 adder datapath, feeding the rounding stage. It accepts two IEEE-754 single-precision operands and orders them by magnitude. It right-shifts the smaller mantissa by the exponent difference, SHIFT_STEP bits per cycle, and emits both mantissas in the 28-bit extended format consumed downstream. In that format, bits [27:4] are the mantissa with hidden bit, [3] is guard, [2] is round, and [1:0] are sticky.

## Interface
- SIZE_EXP, 8, exponent width
- SIZE_MAN, 28, extended mantissa width (24 mantissa + 4 GRS)
- SHIFT_STEP, 4, maximum right-shift distance per cycle (1..SIZE_MAN)

- i_clk  input  1  clock; single clock domain
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  operand pair valid
- o_ready  output  1  unit can accept operands
- i_data_a  input  32  FP32 operand A
- i_data_b  input  32  FP32 operand B
- o_valid  output  1  aligned result valid
- i_ready  input  1  downstream accepts result
- o_man_big  output  SIZE_MAN  larger-magnitude mantissa, unshifted
- o_man_small  output  SIZE_MAN  smaller mantissa, aligned, sticky-collected
- o_exp  output  SIZE_EXP  common (larger) exponent
- o_sign_big  output  1  sign of larger operand
- o_sign_small  output  1  sign of smaller operand
- o_swap  output  1  1 = operand B was the larger operand

## Operation
- FSM states are IDLE, SHIFT and DONE. o_ready = (state==IDLE). o_valid = (state==DONE).
- IDLE: when i_valid & o_ready, capture the operands:
  - Each operand's mantissa is {hidden, frac[22:0], 4'b0000}, with hidden = (exp != 0).
  - Compare the {exp, frac} magnitudes. The larger operand becomes big. On a tie A is big and o_swap = 0.
  - d = exp_big − exp_small, clamped to SIZE_MAN when d > SIZE_MAN.
  - Next state is DONE if d == 0, else SHIFT with remaining = d.
- SHIFT: each cycle shift by s = min(SHIFT_STEP, remaining).
  - man_small ← (man_small >> s), with bit0 ORed with the OR of all bits shifted out and the old bit0.
  - remaining ← remaining − s. Go to DONE when the new remaining == 0.
- DONE: all outputs are held stable. On o_valid & i_ready go to IDLE.
- No sticky information is ever lost. A shift of SIZE_MAN yields man_small = {27'b0, |original}.
- i_valid while o_ready = 0 is ignored; no queueing.

## Timing
- Reset (asynchronous, immediate): state = IDLE, o_valid = 0, o_ready = 1, all data outputs = 0, remaining = 0.
- Accept in cycle 0. o_valid is first high in cycle 1 + ceil(d/SHIFT_STEP), with d clamped. So d=0 gives cycle 1 and the maximum is 1 + ceil(28/SHIFT_STEP).
- o_ready returns high in the cycle after the output handshake. The next accept is no earlier than that cycle, so there is no overlap between transactions.
- Reset asserted mid-SHIFT or in DONE aborts the transaction. No result is emitted for it.
- Data outputs change only on the capture edge and on SHIFT edges. They never change while o_valid = 1.

## Configuration
- ALIGN_DENORM_EN defined: an operand with exp = 0 is denormal. Its hidden bit is 0 and its effective exponent is 1 for both comparison and d. o_exp reports the effective exponent, so 1 if both operands are denormal.
- ALIGN_DENORM_EN undefined: an operand with exp = 0 is flushed to zero. Its mantissa is forced to 0, its exponent is 0, and its sign is kept.

## Test plan
- A=0x3F800000, B=0x3F800000 -> o_valid in cycle 1; o_man_big = o_man_small = 0x8000000; o_exp=0x7F; o_swap=0.
- A=0x3F800000, B=0x40400000 -> o_swap=1, o_exp=0x80, o_man_big=0xC000000, o_man_small=0x4000000; o_valid in cycle 2.
- A=0x4B000000, B=0x3F800001 (d=23) -> o_man_small=0x0000011 (sticky set), o_man_big=0x8000000; o_valid in cycle 7.
- A=0x7F000000, B=0xBF800000 (d=127, clamped 28) -> o_man_small=0x0000001, o_sign_small=1; o_valid in cycle 8.
- Hold i_ready=0 for 5 cycles in DONE while pulsing i_valid -> outputs stable, o_ready=0, new operands ignored; raise i_ready -> o_ready=1 next cycle.
- Drive i_rst_n low during SHIFT of the d=23 case -> o_valid=0, o_ready=1, outputs 0 immediately; a fresh 1.0+1.0 transaction then completes in cycle 1.

Source files
------------

// File: rtl/align_shift_unit.sv
// FP32 adder alignment stage: orders two operands by magnitude and right-shifts the smaller
// mantissa a few bits per cycle with sticky collection. Define ALIGN_DENORM_EN to keep denormals.
module align_shift_unit #(
  parameter int SIZE_EXP   = 8,
  parameter int SIZE_MAN   = 28,
  parameter int SHIFT_STEP = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [31:0]         i_data_a,
  input  logic [31:0]         i_data_b,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [SIZE_MAN-1:0] o_man_big,
  output logic [SIZE_MAN-1:0] o_man_small,
  output logic [SIZE_EXP-1:0] o_exp,
  output logic                o_sign_big,
  output logic                o_sign_small,
  output logic                o_swap
);

  localparam int REM_W = $clog2(SIZE_MAN + 1);
  localparam logic [REM_W-1:0]    REM_MAX  = REM_W'(SIZE_MAN);
  localparam logic [REM_W-1:0]    REM_STEP = REM_W'(SHIFT_STEP);
  localparam logic [SIZE_EXP-1:0] EXP_MAX  = SIZE_EXP'(SIZE_MAN);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef struct packed {
    logic                sign;
    logic [SIZE_EXP-1:0] exp;
    logic [SIZE_MAN-1:0] man;
  } operand_t;

  // Mantissa goes in the top 24 bits; the low GRS bits start out clear.
  function automatic operand_t unpack(input logic [31:0] word);
    operand_t op;
    op.sign = word[31];
    op.man  = '0;
    if (word[30:23] == 8'd0) begin
`ifdef ALIGN_DENORM_EN
      op.exp = SIZE_EXP'(1);
      op.man[SIZE_MAN-1 -: 24] = {1'b0, word[22:0]};
`else
      op.exp = '0;
`endif
    end else begin
      op.exp = SIZE_EXP'(word[30:23]);
      op.man[SIZE_MAN-1 -: 24] = {1'b1, word[22:0]};
    end
    return op;
  endfunction

  state_t              state;
  state_t              state_next;
  logic [SIZE_MAN-1:0] man_big;
  logic [SIZE_MAN-1:0] man_small;
  logic [SIZE_EXP-1:0] exp_big;
  logic                sign_big;
  logic                sign_small;
  logic                swap;
  logic [REM_W-1:0]    remaining;

  operand_t            op_a;
  operand_t            op_b;
  operand_t            op_big;
  operand_t            op_small;
  logic                a_is_big;
  logic [SIZE_EXP-1:0] exp_diff;
  logic [REM_W-1:0]    shift_total;
  logic                accept;

  logic [REM_W-1:0]    step;
  logic [REM_W-1:0]    remaining_next;
  logic [SIZE_MAN-1:0] out_mask;
  logic [SIZE_MAN-1:0] man_shifted;
  logic                lost;

  assign accept = i_valid && (state == IDLE);

  // Comparing exponent then full mantissa (hidden bit included) orders denormals correctly too.
  always_comb begin
    op_a        = unpack(i_data_a);
    op_b        = unpack(i_data_b);
    a_is_big    = {op_a.exp, op_a.man} >= {op_b.exp, op_b.man};
    op_big      = a_is_big ? op_a : op_b;
    op_small    = a_is_big ? op_b : op_a;
    exp_diff    = op_big.exp - op_small.exp;
    shift_total = (exp_diff > EXP_MAX) ? REM_MAX : REM_W'(exp_diff);
  end

  always_comb begin
    step           = (remaining < REM_STEP) ? remaining : REM_STEP;
    out_mask       = ~({SIZE_MAN{1'b1}} << step);
    lost           = |(man_small & out_mask);
    man_shifted    = man_small >> step;
    man_shifted[0] = man_shifted[0] | lost | man_small[0];
    remaining_next = remaining - step;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_valid) begin
          state_next = (shift_total == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (remaining_next == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Data only moves on capture and shift edges, so it is frozen while the result is offered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      man_big    <= '0;
      man_small  <= '0;
      exp_big    <= '0;
      sign_big   <= 1'b0;
      sign_small <= 1'b0;
      swap       <= 1'b0;
      remaining  <= '0;
    end else if (accept) begin
      man_big    <= op_big.man;
      man_small  <= op_small.man;
      exp_big    <= op_big.exp;
      sign_big   <= op_big.sign;
      sign_small <= op_small.sign;
      swap       <= !a_is_big;
      remaining  <= shift_total;
    end else if (state == SHIFT) begin
      man_small  <= man_shifted;
      remaining  <= remaining_next;
    end
  end

  assign o_ready      = (state == IDLE);
  assign o_valid      = (state == DONE);
  assign o_man_big    = man_big;
  assign o_man_small  = man_small;
  assign o_exp        = exp_big;
  assign o_sign_big   = sign_big;
  assign o_sign_small = sign_small;
  assign o_swap       = swap;

endmodule
